// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared geometry constants, capture state encoding and the
//               framebuffer row-base helper for the LCD capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Panel geometry: 160x144 pixels, 2 bits per pixel, 4 pixels per byte.
  localparam int LCD_W   = 160;
  localparam int LCD_H   = 144;
  localparam int LCD_BPL = 40;
  localparam int FB_AW   = 13;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_GAP   = 2'd1,
    ACTIVE     = 2'd2
  } cap_state_t;

  // y*40 as two shifted adds, kept at framebuffer address width.
  function automatic logic [FB_AW-1:0] row_base(input logic [7:0] y);
    logic [FB_AW-1:0] yw;
    yw = {{(FB_AW-8){1'b0}}, y};
    return (yw << 5) + (yw << 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_edge_sync
// Description : Two-flop synchroniser for one asynchronous LCD strobe followed
//               by a third flop that turns the chosen transition into a
//               single-clk pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_edge_sync #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic pulse
);

  // sh[0], sh[1] form the synchroniser; sh[2] holds the previous synced level.
  logic [2:0] sh;

  // Shift the raw input through the synchroniser and history flop.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sh <= 3'b000;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  generate
    if (FALLING) begin : g_fall
      assign pulse = ~sh[1] & sh[2];
    end else begin : g_rise
      assign pulse = sh[1] & ~sh[2];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lcd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_capture
// Description : Captures a 160x144 2bpp LCD pixel stream (cp/st/s strobes and
//               active-low data lines) into byte writes for a framebuffer,
//               four pixels per byte, with line/frame abort detection.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_capture
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             cp,
  input  logic             st,
  input  logic             s,
  input  logic             nld0,
  input  logic             nld1,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata,
  output logic             frame_done,
  output logic             line_err,
  output logic             frame_err,
  output logic             in_frame
);

  localparam logic [7:0] X_LAST = 8'(LCD_W - 1);
  localparam logic [7:0] Y_END  = 8'(LCD_H);

  // --------------------------------------------------------------------------
  // Strobe synchronisers and edge detectors
  // --------------------------------------------------------------------------
  logic cp_fall;
  logic st_rise;
  logic s_rise;

  lcd_edge_sync #(.FALLING(1'b1)) u_cp_sync (
    .clk    (clk),
    .nreset (nreset),
    .din    (cp),
    .pulse  (cp_fall)
  );

  lcd_edge_sync #(.FALLING(1'b0)) u_st_sync (
    .clk    (clk),
    .nreset (nreset),
    .din    (st),
    .pulse  (st_rise)
  );

  lcd_edge_sync #(.FALLING(1'b0)) u_s_sync (
    .clk    (clk),
    .nreset (nreset),
    .din    (s),
    .pulse  (s_rise)
  );

  // --------------------------------------------------------------------------
  // Data-line synchroniser: same two-flop depth as the strobes so the value
  // at stage two lines up with the cycle in which the cp fall is seen.
  // --------------------------------------------------------------------------
  logic [1:0] nld_s1;
  logic [1:0] nld_s2;
  logic [1:0] pix;

  // Two-flop synchroniser for {nld1, nld0}.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nld_s1 <= 2'b00;
      nld_s2 <= 2'b00;
    end else begin
      nld_s1 <= {nld1, nld0};
      nld_s2 <= nld_s1;
    end
  end

  assign pix = ~nld_s2;

  // --------------------------------------------------------------------------
  // Capture state and datapath registers
  // --------------------------------------------------------------------------
  cap_state_t       state, state_n;
  logic [7:0]       x, x_n;
  logic [7:0]       y, y_n;
  logic [5:0]       sr, sr_n;        // first three pixels of the current group
  logic             we_n;
  logic [FB_AW-1:0] addr_n;
  logic [7:0]       wdata_n;
  logic             done_n;
  logic             lerr_n;
  logic             ferr_n;
  logic             in_frame_n;
  logic [7:0]       y_inc;

  // State and datapath register bank; reset drops any partial line.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= WAIT_FRAME;
      x          <= 8'd0;
      y          <= 8'd0;
      sr         <= 6'd0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= 8'd0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      in_frame   <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      sr         <= sr_n;
      fb_we      <= we_n;
      fb_addr    <= addr_n;
      fb_wdata   <= wdata_n;
      frame_done <= done_n;
      line_err   <= lerr_n;
      frame_err  <= ferr_n;
      in_frame   <= in_frame_n;
    end
  end

  // Next-state and output decode. Priority is s, then st, then cp: a frame
  // start wins over everything, and a cp fall that coincides with a strobe
  // is dropped because the strobe redefines the position it would land at.
  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    sr_n       = sr;
    we_n       = 1'b0;
    addr_n     = fb_addr;
    wdata_n    = fb_wdata;
    done_n     = 1'b0;
    lerr_n     = 1'b0;
    ferr_n     = 1'b0;
    in_frame_n = in_frame;
    y_inc      = y + 8'd1;

    if (s_rise) begin
      // Only a frame that has actually produced pixels counts as aborted.
      ferr_n     = in_frame && ((y != 8'd0) || (state == ACTIVE));
      y_n        = 8'd0;
      x_n        = 8'd0;
      sr_n       = 6'd0;
      in_frame_n = 1'b1;
      // A coincident st opens line 0 straight away.
      state_n    = st_rise ? ACTIVE : LINE_GAP;
    end else if (st_rise) begin
      case (state)
        LINE_GAP: begin
          x_n     = 8'd0;
          sr_n    = 6'd0;
          state_n = ACTIVE;
        end
        ACTIVE: begin
          // Restart the same row; the partial byte is never written.
          if (x != 8'd0) begin
            lerr_n = 1'b1;
            x_n    = 8'd0;
            sr_n   = 6'd0;
          end
        end
        default: begin
        end
      endcase
    end else if (cp_fall && (state == ACTIVE)) begin
      sr_n = {sr[3:0], pix};
      if (x[1:0] == 2'd3) begin
        we_n    = 1'b1;
        addr_n  = row_base(y) + {{(FB_AW-6){1'b0}}, x[7:2]};
        wdata_n = {sr, pix};
      end
      x_n = x + 8'd1;
      if (x == X_LAST) begin
        y_n = y_inc;
        if (y_inc == Y_END) begin
          done_n     = 1'b1;
          in_frame_n = 1'b0;
          state_n    = WAIT_FRAME;
        end else begin
          state_n    = LINE_GAP;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_capture
// Description : Directed self-checking bench for lcd_capture with a
//               pixel-level reference model and a per-cycle write checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_capture;

  logic        clk    = 1'b0;
  logic        nreset = 1'b0;
  logic        cp     = 1'b1;
  logic        st     = 1'b0;
  logic        s      = 1'b0;
  logic        nld0   = 1'b1;
  logic        nld1   = 1'b1;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;
  logic        in_frame;

  lcd_capture dut (
    .clk        (clk),
    .nreset     (nreset),
    .cp         (cp),
    .st         (st),
    .s          (s),
    .nld0       (nld0),
    .nld1       (nld1),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .in_frame   (in_frame)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_writes = 0;
  int          n_done   = 0;
  int          n_lerr   = 0;
  int          n_ferr   = 0;
  logic [12:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          cp_half  = 2;

  // Reference model: pixel position within the frame and what must be written.
  logic [20:0] exp_q[$];
  logic [1:0]  m_buf[4];
  int          m_x, m_y;
  bit          m_active, m_in_frame;
  int          m_exp_done, m_exp_lerr, m_exp_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  task automatic m_reset();
    m_x = 0; m_y = 0; m_active = 0; m_in_frame = 0;
    m_exp_done = 0; m_exp_lerr = 0; m_exp_ferr = 0;
    exp_q.delete();
  endtask

  task automatic m_s();
    if (m_in_frame && (m_y != 0 || m_active)) m_exp_ferr++;
    m_x = 0; m_y = 0; m_active = 0; m_in_frame = 1;
  endtask

  task automatic m_st();
    if (m_in_frame) begin
      if (!m_active) begin
        m_active = 1; m_x = 0;
      end else if (m_x != 0) begin
        m_exp_lerr++; m_x = 0;
      end
    end
  endtask

  task automatic m_pix(input logic [1:0] p);
    if (m_in_frame && m_active) begin
      m_buf[m_x % 4] = p;
      if (m_x % 4 == 3)
        exp_q.push_back({13'(m_y * 40 + m_x / 4), m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
      m_x++;
      if (m_x == 160) begin
        m_active = 0;
        m_y++;
        if (m_y == 144) begin
          m_exp_done++;
          m_in_frame = 0;
        end
      end
    end
  endtask

  function automatic logic [1:0] pat(input int mode, input int i);
    case (mode)
      0:       return 2'd2;
      1:       return 2'(i);
      default: return 2'(i * 3 + i / 4);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input logic [1:0] p);
    nld1 = ~p[1]; nld0 = ~p[0]; cp = 1'b0;
    m_pix(p);
    tick(cp_half);
    cp = 1'b1;
    tick(cp_half);
  endtask

  task automatic line(input int n, input int mode);
    for (int i = 0; i < n; i++) pix(pat(mode, i));
  endtask

  task automatic strobe(input bit do_s, input bit do_st);
    s = do_s; st = do_st;
    if (do_s)  m_s();
    if (do_st) m_st();
    tick(2);
    s = 1'b0; st = 1'b0;
    tick(2);
  endtask

  task automatic apply_reset();
    nreset = 1'b0; cp = 1'b1; st = 1'b0; s = 1'b0; nld0 = 1'b1; nld1 = 1'b1;
    tick(3);
    check("rst_we",        fb_we,      0);
    check("rst_addr",      fb_addr,    0);
    check("rst_wdata",     fb_wdata,   0);
    check("rst_done",      frame_done, 0);
    check("rst_line_err",  line_err,   0);
    check("rst_frame_err", frame_err,  0);
    check("rst_in_frame",  in_frame,   0);
    m_reset();
    n_writes = 0; n_done = 0; n_lerr = 0; n_ferr = 0;
    nreset = 1'b1;
    tick(3);
  endtask

  task automatic checkpoint(input string tag);
    tick(6);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_frame_done"},     n_done,       m_exp_done);
    check({tag, "_line_err"},       n_lerr,       m_exp_lerr);
    check({tag, "_frame_err"},      n_ferr,       m_exp_ferr);
    check({tag, "_in_frame"},       in_frame,     m_in_frame);
  endtask

  // Per-cycle output checker: every write must be the next one the model expects.
  task automatic compare_loop();
    logic        prev_we;
    logic [20:0] e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (fb_we) begin
          n_writes++;
          last_addr = fb_addr;
          last_data = fb_wdata;
          check("we_one_clk", prev_we, 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL write_unexpected: got addr %0d data 0x%02h, required no write", fb_addr, fb_wdata);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", fb_addr,  e[20:8]);
            check("write_data", fb_wdata, e[7:0]);
          end
        end
        if (frame_done) n_done++;
        if (line_err)   n_lerr++;
        if (frame_err)  n_ferr++;
      end
      prev_we = fb_we;
    end
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // Reset state and group packing with exact write latency.
    apply_reset();
    cp_half = 2;
    strobe(1, 0);
    strobe(0, 1);
    pix(2'd3); pix(2'd0); pix(2'd1);
    nld1 = 1'b0; nld0 = 1'b1; cp = 1'b0;
    m_pix(2'd2);
    tick(2);
    check("pack_we_early", fb_we, 0);
    cp = 1'b1;
    tick(1);
    check("pack_we",   fb_we,    1);
    check("pack_addr", fb_addr,  0);
    check("pack_data", fb_wdata, 8'hC6);
    tick(1);
    checkpoint("pack");

    // Short line followed by a full line on the same row.
    apply_reset();
    strobe(1, 0);
    strobe(0, 1);
    line(50, 1);
    strobe(0, 1);
    checkpoint("short");
    check("short_line_err_cnt", n_lerr,   1);
    check("short_writes",       n_writes, 12);
    check("short_last_addr",    last_addr, 11);
    line(160, 1);
    checkpoint("reline");
    check("reline_writes",    n_writes,  52);
    check("reline_last_addr", last_addr, 39);
    check("reline_last_data", last_data, 8'h1B);

    // Frame abort in the middle of line 10.
    apply_reset();
    cp_half = 1;
    strobe(1, 0);
    for (int l = 0; l < 10; l++) begin
      strobe(0, 1);
      line(160, 2);
    end
    strobe(0, 1);
    line(20, 2);
    strobe(1, 0);
    checkpoint("abort");
    check("abort_frame_err_cnt", n_ferr,   1);
    check("abort_writes",        n_writes, 405);
    strobe(0, 1);
    line(4, 1);
    checkpoint("abort_restart");
    check("abort_restart_addr", last_addr, 0);

    // Simultaneous s and st edges.
    apply_reset();
    strobe(1, 1);
    line(160, 1);
    checkpoint("simul");
    check("simul_writes",    n_writes,        40);
    check("simul_errors",    n_lerr + n_ferr, 0);
    check("simul_last_addr", last_addr,       39);

    // Reset in the middle of line 5, then stray strobes before a new frame.
    apply_reset();
    strobe(1, 0);
    for (int l = 0; l < 5; l++) begin
      strobe(0, 1);
      line(160, 2);
    end
    strobe(0, 1);
    line(38, 2);
    checkpoint("pre_reset");
    apply_reset();
    strobe(0, 1);
    line(8, 2);
    tick(6);
    check("stray_no_write", n_writes, 0);
    check("stray_in_frame", in_frame, 0);
    strobe(1, 0);
    strobe(0, 1);
    line(4, 2);
    checkpoint("post_reset");
    check("post_reset_writes", n_writes,  1);
    check("post_reset_addr",   last_addr, 0);

    // Nominal full frame, every pixel value 2.
    apply_reset();
    strobe(1, 0);
    for (int l = 0; l < 144; l++) begin
      strobe(0, 1);
      line(160, 0);
    end
    checkpoint("frame");
    check("frame_writes",     n_writes,  5760);
    check("frame_done_cnt",   n_done,    1);
    check("frame_in_frame",   in_frame,  0);
    check("frame_last_addr",  last_addr, 5759);
    check("frame_last_data",  last_data, 8'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; at least 4x the cp frequency.
REQ-003 nreset  in  1  asynchronous active-low reset.
REQ-004 cp  in  1  LCD pixel clock, asynchronous to clk.
REQ-005 st  in  1  LCD line-start strobe, asynchronous.
REQ-006 s  in  1  LCD frame-start (vsync) strobe, asynchronous.
REQ-007 nld0, nld1  in  1 each  active-low pixel data lines from the pixel mux.
REQ-008 fb_we  out  1  framebuffer write strobe, one clk wide.
REQ-009 fb_addr  out  13  byte address, y*40 + x/4, range 0..5759.
REQ-010 fb_wdata  out  8  four packed 2-bit pixels; first pixel of the group in [7:6], last in [1:0].
REQ-011 frame_done  out  1  one-clk pulse after line 143 completes.
REQ-012 line_err  out  1  one-clk pulse on an aborted line.
REQ-013 frame_err  out  1  one-clk pulse on an aborted frame.
REQ-014 in_frame  out  1  high from frame start until frame_done or abort.

Function
REQ-015 cp, st, s, nld0 and nld1 SHALL each pass through a two-flop synchroniser of equal depth, so data stays aligned with cp.
REQ-016 Edges SHALL be detected on the synchronised signals with a third flop: rising edge for st and s, falling edge for cp.
REQ-017 Pixel value SHALL be {~nld1, ~nld0}, sampled in the clk cycle in which the cp falling edge is detected.
REQ-018 States SHALL be WAIT_FRAME, LINE_GAP and ACTIVE.
- s rising from any state: y=0, x=0, state LINE_GAP, in_frame=1.
- st rising in LINE_GAP: x=0, state ACTIVE.
- cp falling in ACTIVE: store the pixel, x+=1.
- cp falling in any other state: ignored.
REQ-019 On the 4th pixel of a group (x[1:0]==3 before increment), fb_we SHALL assert one clk later, with fb_addr = y*40 + x[7:2] and fb_wdata holding the four pixels.
REQ-020 After pixel x=159: state LINE_GAP, y+=1.
REQ-021 If y becomes 144: frame_done pulses in the same cycle as the y increment, in_frame drops and state becomes WAIT_FRAME.
REQ-022 st rising in ACTIVE with x!=0 SHALL pulse line_err, discard the partial byte (no fb_we) and restart the same y at x=0.
REQ-023 s rising while in_frame=1 and (y!=0 or state==ACTIVE) SHALL pulse frame_err and then restart the frame per REQ-018.
REQ-024 If s and st rising edges are detected in the same cycle, s SHALL be processed first and st SHALL then move LINE_GAP to ACTIVE in that same cycle; the result is state ACTIVE, y=0, x=0.
REQ-025 st rising in WAIT_FRAME SHALL be ignored.
REQ-026 y SHALL never exceed 144 and x SHALL never exceed 160; no counter wraps.
REQ-027 Arithmetic: y*40 SHALL be computed as (y<<5)+(y<<3), at 13-bit width.

Reset
REQ-028 While nreset=0: all synchroniser flops, x, y and the pixel shift register SHALL be 0; state WAIT_FRAME; every output 0.
REQ-029 Reset asserted mid-line SHALL abandon the partial line without a write.
REQ-030 After reset release, capture SHALL resume only after the next s rising edge.

Structure
REQ-031 Package lcd_pkg SHALL hold LCD_W=160, LCD_H=144, LCD_BPL=40, FB_AW=13 and the state enum.
REQ-032 Sub-module lcd_edge_sync SHALL implement the synchroniser plus edge detect, with one instance per strobe (cp, st, s).
REQ-033 Data-line synchronisers SHALL be inline and of equal depth.

Verification
REQ-034 Nominal frame: s, then 144 lines of st plus 160 cp pulses, all pixels=2 (nld1=0, nld0=1).
- Expect 5760 writes with fb_wdata=8'hAA, addresses 0..5759 in order.
- Expect one frame_done.
REQ-035 Packing: line 0 pixels 3,0,1,2.
- Expect write addr 0, data 8'hC6, one clk after the 4th cp fall.
REQ-036 Short line: st, 50 cp, st.
- Expect line_err once, 12 writes at addr 0..11.
- Expect the following full line to rewrite addr 0..39 at y=0.
REQ-037 Frame abort: s mid-line 10.
- Expect frame_err; next line writes start at addr 0.
REQ-038 Simultaneous s+st edges, then 160 cp.
- Expect writes to addr 0..39 and no error pulses.
REQ-039 Reset mid-line 5 (after x=37), release, stray st + cp, then s and st.
- Expect no writes until after s; the first write goes to addr 0.
